// File: rtl/if_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, imem port and IF/ID payload.
interface if_stage_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned CNT_W = 32;

  logic              stall_i;
  logic              flush_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [DATA_W-1:0] imem_rdata_i;
  logic [DATA_W-1:0] ifid_instr_o;
  logic [ADDR_W-1:0] ifid_pc_o;
  logic [ADDR_W-1:0] ifid_pc_plus4_o;
  logic              ifid_valid_o;
  logic              align_err_o;
  logic [CNT_W-1:0]  fetch_count_o;

  // Fetch stage side: drives the imem address and the IF/ID register.
  modport master (
    input  stall_i, flush_i, redirect_i, redirect_pc_i, imem_rdata_i,
    output imem_addr_o, ifid_instr_o, ifid_pc_o, ifid_pc_plus4_o,
           ifid_valid_o, align_err_o, fetch_count_o
  );

  // Surrounding pipeline side: hazard unit, branch resolution, imem, decode.
  modport slave (
    output stall_i, flush_i, redirect_i, redirect_pc_i, imem_rdata_i,
    input  imem_addr_o, ifid_instr_o, ifid_pc_o, ifid_pc_plus4_o,
           ifid_valid_o, align_err_o, fetch_count_o
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: PC register, IF/ID pipeline register, fetch counter.
module if_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(240)
) (
  input logic       clk,
  input logic       rst_n,
  if_stage_if.master bus
);
  localparam int unsigned CNT_W = 32;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [ADDR_W-1:0] ip4_q, ip4_d;
  logic              valid_q, valid_d;
  logic              align_q, align_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] pc_plus4;
  logic              bubble;
  logic              load;

  assign pc_plus4 = pc_q + ADDR_W'(4);
  // Redirect always kills the slot; flush kills it unless redirect already did.
  assign bubble   = bus.redirect_i | bus.flush_i;
  assign load     = ~bus.redirect_i & ~bus.stall_i & ~bus.flush_i;

  // Next-state: redirect > stall > sequential fetch, flush orthogonal on IF/ID.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ip4_d   = ip4_q;
    valid_d = valid_q;
    count_d = count_q;
    align_d = bus.redirect_i & (bus.redirect_pc_i[1:0] != 2'b00);

    if (bus.redirect_i) begin
      pc_d = {bus.redirect_pc_i[ADDR_W-1:2], 2'b00};
    end else if (!bus.stall_i) begin
      pc_d = pc_plus4;
    end

    if (bubble) begin
      instr_d = '0;
      ipc_d   = '0;
      ip4_d   = '0;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = bus.imem_rdata_i;
      ipc_d   = pc_q;
      ip4_d   = pc_plus4;
      valid_d = 1'b1;
      count_d = count_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      ip4_q   <= '0;
      valid_q <= 1'b0;
      align_q <= 1'b0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ip4_q   <= ip4_d;
      valid_q <= valid_d;
      align_q <= align_d;
      count_q <= count_d;
    end
  end

  assign bus.imem_addr_o     = pc_q;
  assign bus.ifid_instr_o    = instr_q;
  assign bus.ifid_pc_o       = ipc_q;
  assign bus.ifid_pc_plus4_o = ip4_q;
  assign bus.ifid_valid_o    = valid_q;
  assign bus.align_err_o     = align_q;
  assign bus.fetch_count_o   = count_q;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed plan checks plus randomized run against a reference model.
module tb_if_stage;
  localparam logic [31:0] RST_PC = 32'd240;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic fixed_mode = 1'b1;
  logic [31:0] fixed_word = 32'h2008_0005;
  logic cmp_en = 1'b0;
  int errors = 0;
  int checks = 0;

  if_stage_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  if_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return fixed_mode ? fixed_word : ((a * 32'h9E37_79B1) ^ 32'h1234_5678);
  endfunction

  // Instruction memory: combinational read of the fetch address.
  assign bus.imem_rdata_i = word_at(bus.imem_addr_o);

  // Reference model state.
  logic [31:0] m_pc = RST_PC, m_instr = 0, m_ipc = 0, m_ip4 = 0, m_cnt = 0;
  logic        m_valid = 0, m_align = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= RST_PC; m_instr <= 0; m_ipc <= 0; m_ip4 <= 0;
      m_valid <= 0; m_align <= 0; m_cnt <= 0;
    end else begin
      m_align <= bus.redirect_i && (bus.redirect_pc_i % 4 != 0);
      if (bus.redirect_i) begin
        m_pc <= bus.redirect_pc_i - (bus.redirect_pc_i % 4);
        m_instr <= 0; m_ipc <= 0; m_ip4 <= 0; m_valid <= 0;
      end else if (bus.stall_i) begin
        if (bus.flush_i) begin
          m_instr <= 0; m_ipc <= 0; m_ip4 <= 0; m_valid <= 0;
        end
      end else begin
        m_pc <= m_pc + 4;
        if (bus.flush_i) begin
          m_instr <= 0; m_ipc <= 0; m_ip4 <= 0; m_valid <= 0;
        end else begin
          m_instr <= word_at(m_pc); m_ipc <= m_pc; m_ip4 <= m_pc + 4;
          m_valid <= 1; m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_addr",  bus.imem_addr_o,          m_pc);
      chk("m_instr", bus.ifid_instr_o,         m_instr);
      chk("m_pc",    bus.ifid_pc_o,            m_ipc);
      chk("m_pc4",   bus.ifid_pc_plus4_o,      m_ip4);
      chk("m_valid", 32'(bus.ifid_valid_o),    32'(m_valid));
      chk("m_align", 32'(bus.align_err_o),     32'(m_align));
      chk("m_count", bus.fetch_count_o,        m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] rpc);
    bus.stall_i = s; bus.flush_i = f; bus.redirect_i = r; bus.redirect_pc_i = rpc;
  endtask

  initial begin
    drive(0, 0, 0, 0);
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    #2;
    chk("rst_addr",  bus.imem_addr_o, 32'd240);
    chk("rst_valid", 32'(bus.ifid_valid_o), 0);
    chk("rst_count", bus.fetch_count_o, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_addr", bus.imem_addr_o, 32'd240);

    // Reset release / straight-line fetch
    step();
    chk("t1_pc",    bus.ifid_pc_o, 32'd240);
    chk("t1_pc4",   bus.ifid_pc_plus4_o, 32'd244);
    chk("t1_instr", bus.ifid_instr_o, 32'h2008_0005);
    chk("t1_valid", 32'(bus.ifid_valid_o), 1);
    chk("t1_count", bus.fetch_count_o, 1);
    chk("t2_addr1", bus.imem_addr_o, 32'd244);
    step();
    chk("t2_addr2", bus.imem_addr_o, 32'd248);
    chk("t2_pc2",   bus.ifid_pc_o, 32'd244);

    // Stall, then stall with flush
    drive(1, 0, 0, 0); step();
    chk("t3_hold_addr",  bus.imem_addr_o, 32'd248);
    chk("t3_hold_pc",    bus.ifid_pc_o, 32'd244);
    chk("t3_hold_valid", 32'(bus.ifid_valid_o), 1);
    chk("t3_hold_count", bus.fetch_count_o, 2);
    drive(1, 1, 0, 0); step();
    chk("t3_fl_addr",  bus.imem_addr_o, 32'd248);
    chk("t3_fl_valid", 32'(bus.ifid_valid_o), 0);
    chk("t3_fl_instr", bus.ifid_instr_o, 0);
    chk("t3_fl_count", bus.fetch_count_o, 2);
    drive(0, 0, 0, 0); step();
    chk("t3_rel_pc", bus.ifid_pc_o, 32'd248);
    step();
    chk("t2_addr4",  bus.imem_addr_o, 32'd256);
    chk("t2_count4", bus.fetch_count_o, 4);

    // Redirect wins over stall
    drive(1, 0, 1, 32'h100); step();
    chk("t4_addr",  bus.imem_addr_o, 32'h100);
    chk("t4_valid", 32'(bus.ifid_valid_o), 0);
    chk("t4_align", 32'(bus.align_err_o), 0);
    chk("t4_count", bus.fetch_count_o, 4);
    drive(0, 0, 0, 0); step();
    chk("t4_pc", bus.ifid_pc_o, 32'h100);

    // Misaligned redirect
    drive(0, 0, 1, 32'h103); step();
    chk("t5_addr",  bus.imem_addr_o, 32'h100);
    chk("t5_align", 32'(bus.align_err_o), 1);
    drive(0, 0, 0, 0); step();
    chk("t5_align_off", 32'(bus.align_err_o), 0);

    // Wrap, then asynchronous reset between edges
    drive(0, 0, 1, 32'hFFFF_FFFC); step();
    chk("t6_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0); step();
    chk("t6_pc",   bus.ifid_pc_o, 32'hFFFF_FFFC);
    chk("t6_pc4",  bus.ifid_pc_plus4_o, 0);
    chk("t6_wrap", bus.imem_addr_o, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_addr",  bus.imem_addr_o, 32'd240);
    chk("t6_rst_valid", 32'(bus.ifid_valid_o), 0);
    chk("t6_rst_pc",    bus.ifid_pc_o, 0);
    chk("t6_rst_count", bus.fetch_count_o, 0);
    #1 rst_n = 1'b1;

    // Randomized traffic
    fixed_mode = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      case ($urandom_range(0, 3))
        0: rpc = $urandom & 32'hFFFF_FFFC;
        1: rpc = $urandom;
        2: rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: rpc = 32'($urandom_range(0, 1023));
      endcase
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 7) == 0), rpc);
      step();
    end
    drive(0, 0, 0, 0);
    step();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
